// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU. One request at a time over a valid/ready handshake,
// one quotient bit per cycle, result returned over a second handshake.
// Optional feature macro: DIVIDER_EARLY_OUT_EN (skip the iteration loop for
// divide-by-zero, signed overflow and divisor-larger-than-dividend cases).
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_is_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_div0;
  logic             r_ovf;
  logic             r_valid;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dmag;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_result;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic             w_early;
  logic             w_accept;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic [WIDTH-1:0] w_fix;

  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = r_valid;
  assign o_result = r_result;

  // Operand decode at acceptance: magnitudes, signs and special cases.
  always_comb begin
    w_signed = ~i_op[0];
    w_a_neg  = w_signed & i_dividend[WIDTH-1];
    w_b_neg  = w_signed & i_divisor[WIDTH-1];
    w_a_mag  = w_a_neg ? ('0 - i_dividend) : i_dividend;
    w_b_mag  = w_b_neg ? ('0 - i_divisor) : i_divisor;
    w_div0   = (i_divisor == '0);
    w_ovf    = w_signed & (i_dividend == MIN_NEG) & (i_divisor == '1);
`ifdef DIVIDER_EARLY_OUT_EN
    w_early  = w_div0 | w_ovf | (w_b_mag > w_a_mag);
`else
    w_early  = 1'b0;
`endif
    w_accept = (r_state == S_IDLE) & i_valid & ~i_flush;
  end

  // Restoring step and final sign correction / special-case override.
  always_comb begin
    w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dmag};
    w_q_fin = r_qneg ? ('0 - r_quo) : r_quo;
    w_r_fin = r_rneg ? ('0 - r_rem) : r_rem;
    if (r_div0) begin
      w_q_fin = '1;
      w_r_fin = r_dvd;
    end else if (r_ovf) begin
      w_q_fin = r_dvd;
      w_r_fin = '0;
    end
    w_fix = r_is_rem ? w_r_fin : w_q_fin;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_early ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (r_valid && i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_flush) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Datapath: operand latch, iteration, result register and valid flag.
  // o_valid rises one cycle after entering DONE, giving WIDTH+2 latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_is_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dmag   <= '0;
      r_dvd    <= '0;
      r_result <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_valid <= ~(r_valid & i_ready);
      end else begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_rem <= i_op[1];
            r_qneg   <= w_a_neg ^ w_b_neg;
            r_rneg   <= w_a_neg;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_dmag   <= w_b_mag;
            r_dvd    <= i_dividend;
            r_cnt    <= w_early ? '0 : CW'(WIDTH);
            r_rem    <= w_early ? w_a_mag : '0;
            r_quo    <= w_early ? '0 : w_a_mag;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!i_flush) r_result <= w_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed RV32M cases, special
// results, backpressure, flush/reset abort and randomized operands against an
// arithmetic reference model. Honours DIVIDER_EARLY_OUT_EN for latency.
module tb_iterative_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         i_rst_n, i_flush, i_valid, i_ready;
  logic [1:0]   i_op;
  logic [W-1:0] i_dividend, i_divisor;
  logic         o_ready, o_valid;
  logic [W-1:0] o_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iterative_divider #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic longint mag(input logic [1:0] op, input logic [31:0] v);
    int s;
    s = v;
    if (op[0]) return longint'({32'd0, v});
    return (s < 0) ? -longint'(s) : longint'(s);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIVIDER_EARLY_OUT_EN
    if (b == 32'd0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (mag(op, b) > mag(op, a)) return 2;
`endif
    return W + 2;
  endfunction

  task automatic accept_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    int cnt;
    cnt = 0;
    while (!o_ready && cnt < 60) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1; i_op = op; i_dividend = a; i_divisor = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_op = 2'($urandom); i_dividend = $urandom; i_divisor = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat, cnt;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, a, b);
    accept_op(tag, op, a, b);
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_lat"}, cnt, lat);
    check({tag, "_res"}, o_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_res"}, o_result, exp);
      check({tag, "_hold_vld_rdy"}, {30'd0, o_valid, o_ready}, 32'd2);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({tag, "_post_hs"}, {30'd0, o_valid, o_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    bit          seen;

    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_op = 2'd0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    check("reset_vld_rdy", {30'd0, o_valid, o_ready}, 32'd1);
    check("reset_result", o_result, 32'd0);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 10);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
    run_op("div_m20_3",  2'b00, 32'hFFFF_FFEC, 32'd3, 1);
    run_op("rem_m20_3",  2'b10, 32'hFFFF_FFEC, 32'd3, 0);
    run_op("rem_20_m3",  2'b10, 32'd20, 32'hFFFF_FFFD, 0);
    run_op("div_by0",    2'b00, 32'h8000_0005, 32'd0, 2);
    run_op("remu_by0",   2'b11, 32'h0000_1234, 32'd0, 0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_small", 2'b01, 32'd5, 32'd9, 0);

    // Flush with a request pending in IDLE must not accept it.
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_dividend = 32'd50; i_divisor = 32'd5;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_idle_rdy", {31'd0, o_ready}, 32'd1);

    // Flush at CALC cycle 10.
    accept_op("flush", 2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_vld_rdy", {30'd0, o_valid, o_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1'b1;
    end
    check("flush_no_result", {31'd0, seen}, 32'd0);

    // Reset mid-CALC on a second operation.
    accept_op("rst", 2'b00, 32'd7777, 32'd13);
    repeat (5) @(posedge clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    check("rst_vld_rdy", {30'd0, o_valid, o_ready}, 32'd1);
    check("rst_result", o_result, 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 0);

    // Randomized operands biased toward the interesting corners.
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        2:       a = 32'd0 - $urandom_range(1, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = 32'd0 - $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, the division counterpart to the array multiplier in the execute-stage M-unit. It accepts one operation at a time through a valid/ready handshake and iterates one quotient bit per cycle. It returns a single result word through a second valid/ready handshake. Special cases are resolved to RISC-V-mandated values: divide-by-zero and signed overflow.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and even
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  synchronous active-low reset, sampled on rising edge of i_clk
- i_flush  in  1  abort any in-flight operation (pipeline flush)
- i_valid  in  1  request valid
- o_ready  out  1  divider can accept a request
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_dividend  in  WIDTH  rs1 value
- i_divisor  in  WIDTH  rs2 value
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_result  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid: latch op.
  - Signed ops: convert operands to magnitudes; record quotient sign (sign(a)^sign(b)) and remainder sign (sign(a)).
  - Clear partial remainder; load iteration counter = WIDTH.
  - Go to CALC.
- CALC, one step per cycle:
  - Trial = {rem[WIDTH-1:0], quo[WIDTH-1]} − divisor magnitude (WIDTH+1 bits).
  - Non-negative trial: rem←trial, shift 1 into quotient.
  - Negative trial: rem←shifted value, shift 0 into quotient.
  - Counter decrements; after the WIDTH-th step go to FIX.
- FIX:
  - Apply sign correction; select quotient or remainder per op; register into o_result.
  - Go to DONE.
- DONE: o_valid=1; o_result held stable until i_valid... i.e. until i_ready=1, then go to IDLE.
- Special results override the computed value in FIX, for every op:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = 1 followed by WIDTH−1 zeros, divisor = all ones): quotient = dividend; remainder = 0.
- o_ready=1 only in IDLE; there is no back-to-back acceptance while DONE.
- i_flush:
  - In any state, next state is IDLE and o_valid drops the next cycle; the pending result is discarded.
  - i_flush together with i_valid in IDLE: the request is not accepted.
- Reset (i_rst_n=0 at an edge) in any state:
  - State=IDLE, o_valid=0, o_ready=1 after the edge, o_result=0, counter=0, internal registers=0.
  - Reset mid-operation discards the operation.

## Timing
- Accept at edge E0 (i_valid & o_ready).
- CALC occupies edges E1..E_WIDTH, FIX at E_WIDTH+1, o_valid high after E_WIDTH+2.
- Latency: 34 cycles for WIDTH=32.
- o_valid/o_result stable while i_ready=0; the handshake completes on the edge where o_valid & i_ready.
- A new request is accepted no earlier than the cycle after the result handshake.
- Inputs are sampled only at the acceptance edge; later changes to i_op/operands are ignored.

## Configuration
- DIVIDER_EARLY_OUT_EN defined:
  - In IDLE, divisor 0 or signed overflow skips CALC and enters FIX directly; o_valid is high 2 cycles after acceptance.
  - Divisor magnitude greater than dividend magnitude (unsigned compare) also skips CALC, with quotient 0 and remainder = dividend.
- Not defined: every op takes the full WIDTH+2 latency, with the same result values.

## Test plan
- DIVU 100 / 7 (WIDTH=32) -> o_result=14 exactly 34 cycles after accept; REMU same operands -> 2.
- DIV −20 / 3 -> 0xFFFFFFFA (−6); REM −20 / 3 -> 0xFFFFFFFE (−2); REM 20 / −3 -> 2.
- Divide-by-zero:
  - DIV 0x80000005 / 0 -> 0xFFFFFFFF.
  - REMU 0x1234 / 0 -> 0x1234.
  - Latency 2 cycles with DIVIDER_EARLY_OUT_EN, 34 without.
- Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Backpressure:
  - Hold i_ready=0 for 10 cycles after o_valid -> o_result constant, o_ready=0.
  - Raise i_ready -> IDLE next cycle, new request accepted the following cycle.
- Assert i_flush at CALC cycle 10; assert i_rst_n=0 mid-CALC on a second operation:
  - Both -> IDLE next edge with o_valid=0.
  - A subsequent DIVU 9/3 returns 3.
